fetch_unit: RTL and testbench

- Instruction fetch stage between the program counter and decode.
- Drives the 6-bit `pc` address into the 64x16 instruction ROM (combinational read) and captures the returned 16-bit word with its PC into a small instruction buffer.
- Presents the buffer head to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets), which flush the buffer and restart fetch at the target.

---
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch into a small FIFO with valid/ready output and redirect flush
module fetch_unit #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [PC_W-1:0]          pc,
    input  logic [INSTR_W-1:0]       instr,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [PC_W-1:0]    pcs_q [DEPTH];
    logic [INSTR_W-1:0] ins_q [DEPTH];
    logic               pop, push;

    assign pc        = pc_q;
    assign buf_count = cnt_q;
    assign out_valid = cnt_q != '0;
    assign out_instr = ins_q[rd_q];
    assign out_pc    = pcs_q[rd_q];

    // Handshake decode and next state; a redirect voids any push or pop in its cycle
    always_comb begin
        pop   = out_valid && out_ready;
        push  = fetch_en && !redirect_valid && (cnt_q != FULL || pop);
        pc_d  = redirect_valid ? redirect_pc : push ? pc_q + 1'b1 : pc_q;
        wr_d  = redirect_valid ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d  = redirect_valid ? '0 : pop ? rd_q + 1'b1 : rd_q;
        cnt_d = redirect_valid ? '0 :
                (push && !pop) ? cnt_q + 1'b1 :
                (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    end

    // State registers and buffer storage, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcs_q[i] <= '0;
                ins_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            if (push) begin
                pcs_q[wr_q] <= pc_q;
                ins_q[wr_q] <= instr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a 16'hA000+pc ROM
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pc;
    logic [15:0] instr;
    logic        fetch_en;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [5:0]  out_pc;
    logic        out_ready;
    logic [2:0]  buf_count;
    int          total = 0;
    int          passed = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .buf_count(buf_count)
    );

    assign instr = 16'hA000 + {10'd0, pc};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int e_pc, input int e_cnt, input int e_vld);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".count"}, 32'(buf_count), 32'(e_cnt));
        chk({tag, ".valid"}, 32'(out_valid), 32'(e_vld));
    endtask

    task automatic chk_head(input string tag, input int e_pc);
        chk({tag, ".out_pc"}, 32'(out_pc), 32'(e_pc));
        chk({tag, ".out_instr"}, 32'(out_instr), 32'h0000A000 + 32'(e_pc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        tick();
        chk_st("reset", 0, 0, 0);
        chk("reset.out_pc", 32'(out_pc), 32'd0);
        chk("reset.out_instr", 32'(out_instr), 32'd0);
        rst = 1'b0;
        fetch_en = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_st($sformatf("stream%0d", k), k, 1, 1);
            chk_head($sformatf("stream%0d", k), k - 1);
        end

        out_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_st($sformatf("fill%0d", k), k > 4 ? 4 : k, k > 4 ? 4 : k, 1);
            chk("fill.out_pc", 32'(out_pc), 32'd0);
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk_st($sformatf("drainfull%0d", j), 4 + j, 4, 1);
            chk_head($sformatf("drainfull%0d", j), j);
        end

        redirect_valid = 1'b1; redirect_pc = 6'd62;
        tick();
        redirect_valid = 1'b0;
        chk_st("redir62", 62, 0, 0);
        tick(); chk_st("wrap0", 63, 1, 1); chk_head("wrap0", 62);
        tick(); chk_st("wrap1", 0, 1, 1);  chk_head("wrap1", 63);
        tick(); chk_st("wrap2", 1, 1, 1);  chk_head("wrap2", 0);
        tick(); chk_st("wrap3", 2, 1, 1);  chk_head("wrap3", 1);

        out_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 5; k++) tick();
        chk_st("full", 4, 4, 1);
        chk_head("full", 0);
        redirect_valid = 1'b1; redirect_pc = 6'd20; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk_st("redir20", 20, 0, 0);
        tick(); chk_st("post20a", 21, 1, 1); chk_head("post20a", 20);
        tick(); chk_st("post20b", 22, 1, 1); chk_head("post20b", 21);

        redirect_valid = 1'b1; redirect_pc = 6'd10;
        tick();
        chk_st("redir10", 10, 0, 0);
        redirect_pc = 6'd30;
        tick();
        redirect_valid = 1'b0;
        chk_st("redir30", 30, 0, 0);
        tick(); chk_st("post30", 31, 1, 1); chk_head("post30", 30);

        out_ready = 1'b0;
        tick(); chk_st("stall1", 32, 2, 1);
        tick(); chk_st("stall2", 33, 3, 1);
        fetch_en = 1'b0; out_ready = 1'b1;
        tick(); chk_st("nofetch1", 33, 2, 1); chk_head("nofetch1", 31);
        tick(); chk_st("nofetch2", 33, 1, 1); chk_head("nofetch2", 32);
        tick(); chk_st("nofetch3", 33, 0, 0);

        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); chk_st("refill1", 34, 1, 1); chk_head("refill1", 33);
        tick(); chk_st("refill2", 35, 2, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_st("async_rst", 0, 0, 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick(); chk_st("restart1", 1, 1, 1); chk_head("restart1", 0);
        tick(); chk_st("restart2", 2, 1, 1); chk_head("restart2", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
